// File: rtl/ifetch_bus_ctrl.sv
// Instruction-fetch bus interface: req/ack handshake to instruction memory,
// post-reset startup hold, and a one-word buffer for fetches returned while stalled.
module ifetch_bus_ctrl #(
  parameter int STARTUP_CYCLES = 4,
  parameter int CNT_W          = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  input  logic        Ext_Stall,
  input  logic        Inst_Ack,
  input  logic [31:0] Inst_RData,
  output logic        Inst_Req,
  output logic [29:0] Inst_Addr,
  output logic        Inst_Stall,
  output logic        Startup_Stall,
  output logic [31:0] IF_Instruction
);

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STARTUP_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [31:0]       buffer;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^IF_PC[1:0];

  // Inst_Req and Startup_Stall are registered alongside the state so they
  // follow the state exactly; acks outside FETCH fall through untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= STARTUP;
      count         <= '0;
      buffer        <= '0;
      Inst_Req      <= 1'b0;
      Startup_Stall <= 1'b1;
    end else begin
      case (state)
        STARTUP: begin
          count <= count + 1'b1;
          if (count == LAST_COUNT) begin
            state         <= FETCH;
            Inst_Req      <= 1'b1;
            Startup_Stall <= 1'b0;
          end
        end
        FETCH: begin
          if (Inst_Ack && Ext_Stall) begin
            buffer   <= Inst_RData;
            state    <= HOLD;
            Inst_Req <= 1'b0;
          end
        end
        HOLD: begin
          if (!Ext_Stall) begin
            state    <= FETCH;
            Inst_Req <= 1'b1;
          end
        end
        default: begin
          state         <= STARTUP;
          count         <= '0;
          Inst_Req      <= 1'b0;
          Startup_Stall <= 1'b1;
        end
      endcase
    end
  end

  assign Inst_Addr  = IF_PC[31:2];
  assign Inst_Stall = Inst_Req & ~Inst_Ack;

  // Returned data bypasses straight to IF/ID in the ack cycle; otherwise the
  // buffer is shown, except during startup where a NOP is presented.
  always_comb begin
    IF_Instruction = buffer;
    if (Startup_Stall)
      IF_Instruction = 32'h0000_0000;
    else if (Inst_Req && Inst_Ack)
      IF_Instruction = Inst_RData;
  end

endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// Randomized, self-checking bench for ifetch_bus_ctrl against a behavioural model.
module tb_ifetch_bus_ctrl;

  localparam int STARTUP_CYCLES = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IF_PC = 32'h0040_0000;
  logic        Ext_Stall = 1'b0;
  logic        Inst_Ack = 1'b0;
  logic [31:0] Inst_RData = 32'h0;
  logic        Inst_Req;
  logic [29:0] Inst_Addr;
  logic        Inst_Stall;
  logic        Startup_Stall;
  logic [31:0] IF_Instruction;

  int errors = 0;
  int checks = 0;

  // Behavioural model: remaining startup cycles, whether a word is parked, and that word
  int          m_startup_left;
  bit          m_hold;
  logic [31:0] m_buf;
  bit          m_advanced;

  ifetch_bus_ctrl #(.STARTUP_CYCLES(STARTUP_CYCLES), .CNT_W(3)) dut (
    .clock(clock),
    .reset(reset),
    .IF_PC(IF_PC),
    .Ext_Stall(Ext_Stall),
    .Inst_Ack(Inst_Ack),
    .Inst_RData(Inst_RData),
    .Inst_Req(Inst_Req),
    .Inst_Addr(Inst_Addr),
    .Inst_Stall(Inst_Stall),
    .Startup_Stall(Startup_Stall),
    .IF_Instruction(IF_Instruction)
  );

  always #5 clock = ~clock;

  function automatic logic exp_startup();
    return m_startup_left > 0;
  endfunction

  function automatic logic exp_req();
    return (m_startup_left == 0) && !m_hold;
  endfunction

  function automatic logic exp_stall();
    return exp_req() && !Inst_Ack;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (m_startup_left > 0) return 32'h0;
    if (exp_req() && Inst_Ack) return Inst_RData;
    return m_buf;
  endfunction

  task automatic model_reset();
    m_startup_left = STARTUP_CYCLES;
    m_hold         = 1'b0;
    m_buf          = 32'h0;
    m_advanced     = 1'b0;
  endtask

  // One fetch per request; a word returned under stall is parked until the stall clears
  task automatic model_edge();
    m_advanced = 1'b0;
    if (reset) model_reset();
    else if (m_startup_left > 0) m_startup_left--;
    else if (!m_hold) begin
      if (Inst_Ack) begin
        if (Ext_Stall) begin
          m_hold = 1'b1;
          m_buf  = Inst_RData;
        end else begin
          m_advanced = 1'b1;
        end
      end
    end else if (!Ext_Stall) begin
      m_hold     = 1'b0;
      m_advanced = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int startup_cnt;
    int first_req;
    bit stall_seen;
    $display("[TB] test_reset");
    model_reset();
    Inst_Ack   = 1'b1;
    Inst_RData = $urandom;
    tick();
    tick();
    checks++; if (Inst_Req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", Inst_Req); end
    checks++; if (Startup_Stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_startup: got %b expected 1", Startup_Stall); end
    checks++; if (Inst_Stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", Inst_Stall); end
    checks++; if (IF_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", IF_Instruction); end
    checks++; if (Inst_Addr !== IF_PC[31:2]) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", Inst_Addr, IF_PC[31:2]); end
    reset = 1'b0;
    startup_cnt = 0; first_req = 0; stall_seen = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      Inst_RData = $urandom;
      @(negedge clock);
      if (Startup_Stall) startup_cnt++;
      if (Inst_Req && first_req == 0) first_req = cyc;
      if (Inst_Stall) stall_seen = 1'b1;
      checks++; if (IF_Instruction !== exp_instr()) begin errors++; $display("[TB] FAIL startup_instr c%0d: got %h expected %h", cyc, IF_Instruction, exp_instr()); end
      tick();
      if (m_advanced) IF_PC = IF_PC + 32'd4;
    end
    checks++; if (startup_cnt != STARTUP_CYCLES) begin errors++; $display("[TB] FAIL startup_len: got %0d expected %0d", startup_cnt, STARTUP_CYCLES); end
    checks++; if (first_req != STARTUP_CYCLES + 1) begin errors++; $display("[TB] FAIL first_req_cycle: got %0d expected %0d", first_req, STARTUP_CYCLES + 1); end
    checks++; if (stall_seen) begin errors++; $display("[TB] FAIL startup_stall_seen: got 1 expected 0"); end
  endtask

  task automatic test_wait_states();
    $display("[TB] test_wait_states");
    IF_PC     = 32'h0040_0010;
    Ext_Stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Inst_Ack   = (i == 3);
      Inst_RData = (i == 3) ? 32'h2408_0005 : $urandom;
      @(negedge clock);
      checks++; if (Inst_Addr !== 30'h0010_0004) begin errors++; $display("[TB] FAIL wait_addr i%0d: got %h expected 00100004", i, Inst_Addr); end
      checks++; if (Inst_Req !== 1'b1) begin errors++; $display("[TB] FAIL wait_req i%0d: got %b expected 1", i, Inst_Req); end
      checks++; if (Inst_Stall !== (i < 3)) begin errors++; $display("[TB] FAIL wait_stall i%0d: got %b expected %b", i, Inst_Stall, (i < 3)); end
      if (i == 3) begin
        checks++; if (IF_Instruction !== 32'h2408_0005) begin errors++; $display("[TB] FAIL wait_instr: got %h expected 24080005", IF_Instruction); end
      end
      tick();
    end
    IF_PC = IF_PC + 32'd4;
  endtask

  task automatic test_back_to_back();
    logic [31:0] sent[$];
    logic [31:0] got[$];
    int req_cnt;
    bit stall_seen;
    logic [31:0] base;
    $display("[TB] test_back_to_back");
    base = IF_PC; req_cnt = 0; stall_seen = 0;
    Inst_Ack = 1'b1; Ext_Stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      IF_PC      = base + 32'(4 * i);
      Inst_RData = {$urandom_range(0, 32'h00FF_FFFF) & 32'h00FF_FFFF} << 8 | 32'(i);
      sent.push_back(Inst_RData);
      @(negedge clock);
      if (Inst_Req) req_cnt++;
      if (Inst_Stall) stall_seen = 1'b1;
      if (Inst_Req && Inst_Ack) got.push_back(IF_Instruction);
      checks++; if (Inst_Addr !== IF_PC[31:2]) begin errors++; $display("[TB] FAIL b2b_addr i%0d: got %h expected %h", i, Inst_Addr, IF_PC[31:2]); end
      tick();
    end
    IF_PC = IF_PC + 32'd4;
    checks++; if (req_cnt != 8) begin errors++; $display("[TB] FAIL b2b_reqs: got %0d expected 8", req_cnt); end
    checks++; if (stall_seen) begin errors++; $display("[TB] FAIL b2b_stall: got 1 expected 0"); end
    checks++; if (got.size() != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_hold();
    int acks;
    $display("[TB] test_hold");
    IF_PC = 32'h0040_0100;
    Inst_Ack = 1'b1; Ext_Stall = 1'b1; Inst_RData = 32'h8C09_0000;
    @(negedge clock);
    acks = (Inst_Req && Inst_Ack) ? 1 : 0;
    checks++; if (IF_Instruction !== 32'h8C09_0000) begin errors++; $display("[TB] FAIL hold_ack_instr: got %h expected 8c090000", IF_Instruction); end
    checks++; if (Inst_Stall !== 1'b0) begin errors++; $display("[TB] FAIL hold_ack_stall: got %b expected 0", Inst_Stall); end
    tick();
    for (int i = 0; i < 6; i++) begin
      Ext_Stall  = (i < 5);
      Inst_Ack   = 1'($urandom_range(0, 1));
      Inst_RData = $urandom;
      @(negedge clock);
      if (Inst_Req && Inst_Ack) acks++;
      checks++; if (Inst_Req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req i%0d: got %b expected 0", i, Inst_Req); end
      checks++; if (IF_Instruction !== 32'h8C09_0000) begin errors++; $display("[TB] FAIL hold_instr i%0d: got %h expected 8c090000", i, IF_Instruction); end
      checks++; if (Inst_Stall !== 1'b0) begin errors++; $display("[TB] FAIL hold_stall i%0d: got %b expected 0", i, Inst_Stall); end
      tick();
    end
    IF_PC = IF_PC + 32'd4;
    Inst_Ack = 1'b0; Ext_Stall = 1'b0;
    @(negedge clock);
    checks++; if (Inst_Req !== 1'b1) begin errors++; $display("[TB] FAIL hold_resume_req: got %b expected 1", Inst_Req); end
    checks++; if (Inst_Addr !== 30'h0010_0041) begin errors++; $display("[TB] FAIL hold_resume_addr: got %h expected 00100041", Inst_Addr); end
    checks++; if (acks != 1) begin errors++; $display("[TB] FAIL hold_acks: got %0d expected 1", acks); end
    tick();
  endtask

  task automatic test_reset_mid();
    int startup_cnt;
    int first_req;
    $display("[TB] test_reset_mid");
    Inst_Ack = 1'b0; Ext_Stall = 1'b0;
    @(negedge clock);
    checks++; if (Inst_Req !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_req: got %b expected 1", Inst_Req); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++; if (Inst_Req !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_req: got %b expected 0", Inst_Req); end
    checks++; if (Startup_Stall !== 1'b1) begin errors++; $display("[TB] FAIL mid_async_startup: got %b expected 1", Startup_Stall); end
    tick();
    Inst_Ack = 1'b1; Inst_RData = $urandom;
    @(negedge clock);
    checks++; if (IF_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL mid_late_ack_instr: got %h expected 0", IF_Instruction); end
    tick();
    reset = 1'b0;
    startup_cnt = 0; first_req = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      Inst_RData = $urandom;
      @(negedge clock);
      if (Startup_Stall) startup_cnt++;
      if (Inst_Req && first_req == 0) first_req = cyc;
      if (Startup_Stall) begin
        checks++; if (IF_Instruction !== 32'h0) begin errors++; $display("[TB] FAIL mid_spurious_instr c%0d: got %h expected 0", cyc, IF_Instruction); end
      end
      tick();
      if (m_advanced) IF_PC = IF_PC + 32'd4;
    end
    checks++; if (startup_cnt != STARTUP_CYCLES) begin errors++; $display("[TB] FAIL mid_startup_len: got %0d expected %0d", startup_cnt, STARTUP_CYCLES); end
    checks++; if (first_req != STARTUP_CYCLES + 1) begin errors++; $display("[TB] FAIL mid_first_req: got %0d expected %0d", first_req, STARTUP_CYCLES + 1); end
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    for (int i = 0; i < 300; i++) begin
      Inst_Ack   = ($urandom_range(0, 2) != 0);
      Ext_Stall  = ($urandom_range(0, 2) == 0);
      Inst_RData = $urandom;
      @(negedge clock);
      checks++; if (Inst_Req !== exp_req()) begin errors++; $display("[TB] FAIL rnd_req i%0d: got %b expected %b", i, Inst_Req, exp_req()); end
      checks++; if (Inst_Stall !== exp_stall()) begin errors++; $display("[TB] FAIL rnd_stall i%0d: got %b expected %b", i, Inst_Stall, exp_stall()); end
      checks++; if (Startup_Stall !== exp_startup()) begin errors++; $display("[TB] FAIL rnd_startup i%0d: got %b expected %b", i, Startup_Stall, exp_startup()); end
      checks++; if (IF_Instruction !== exp_instr()) begin errors++; $display("[TB] FAIL rnd_instr i%0d: got %h expected %h", i, IF_Instruction, exp_instr()); end
      checks++; if (Inst_Addr !== IF_PC[31:2]) begin errors++; $display("[TB] FAIL rnd_addr i%0d: got %h expected %h", i, Inst_Addr, IF_PC[31:2]); end
      tick();
      if (m_advanced) begin
        if ($urandom_range(0, 7) == 0) IF_PC = {$urandom_range(0, 32'h3FFF_FFFF) & 32'h3FFF_FFFF, 2'b00};
        else IF_PC = IF_PC + 32'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
